// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and types for the instruction fetch stage
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small shift-style fetch buffer with flush, head always at entry 0
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = cnt - CW'(do_pop);
    assign head    = mem[0];

    // Occupancy: flush empties, otherwise net of push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage: pop shifts toward entry 0; push writes just past the surviving entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush) begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CW'(i)) begin
                        mem[i] <= push_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; define IF_SKID_BUF_EN for a two-entry fetch buffer
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

`ifdef IF_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         req_fire;
    logic         resp_take;
    logic         bypass;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t resp_entry;

    assign imem_addr  = pc;
    assign req_fire   = imem_req && imem_gnt;
    assign resp_entry = {req_pc, imem_rdata};
    // A response goes straight to decode when nothing older is queued ahead of it.
    assign bypass     = resp_take && fifo_empty && !stall_d;
    assign fifo_push  = resp_take && !bypass;
    assign fifo_pop   = !pc_src_e && !stall_d && !fifo_empty;
    assign pc_plus4_d = pc_d + 32'd4;

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM next state: one outstanding request; a redirect while waiting drops the reply.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_fire) state_next = ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_next = ST_IDLE;
                end else if (pc_src_e) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: if (imem_rvalid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Fetch FSM outputs: request only from IDLE with buffer room; accept data only in WAIT.
    always_comb begin
        imem_req  = 1'b0;
        resp_take = 1'b0;
        case (state)
            ST_IDLE: imem_req  = !rst && !fifo_full && !pc_src_e;
            ST_WAIT: resp_take = imem_rvalid && !pc_src_e;
            default: ;
        endcase
    end

    // PC register and the PC of the outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (pc_src_e) begin
                pc <= pc_target_e;
            end else if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (req_fire) begin
                req_pc <= pc;
            end
        end
    end

    // Decode register: redirect clears, stall holds, otherwise head, bypass or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (pc_src_e) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (!stall_d) begin
            if (!fifo_empty) begin
                instr_d <= fifo_head.instr;
                pc_d    <= fifo_head.pc;
                valid_d <= 1'b1;
            end else if (resp_take) begin
                instr_d <= resp_entry.instr;
                pc_d    <= resp_entry.pc;
                valid_d <= 1'b1;
            end else begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_src_e),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

`ifdef IF_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    if_stage #(
        .RESET_PC  (RPC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_d     (stall_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic        pend;
    logic        drop;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat;
    logic        gnt_en;
    logic        force_rvalid;

    logic [31:0] m_pc;
    logic [31:0] m_pc_d;
    logic [31:0] m_instr;
    logic        m_valid;

    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic [31:0] s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0000} ^ a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // One clock cycle: drive memory, sample outputs mid-cycle, compare, then advance the model.
    task automatic tick();
        logic resp;
        logic granted;
        logic exp_req;
        exp_t e;
        resp        = pend && (pend_cnt == 0);
        imem_rvalid = resp || force_rvalid;
        imem_rdata  = resp ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        imem_gnt    = gnt_en;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid_d;
        s_instr = instr_d;
        s_pc    = pc_d;
        s_pc4   = pc_plus4_d;
        exp_req = !pend && (q.size() < DEPTH) && !pc_src_e;
        check1("imem_req", s_req, exp_req);
        if (s_req) check("imem_addr", s_addr, m_pc);
        check1("valid_d", s_valid, m_valid);
        if (m_valid) begin
            check("pc_d", s_pc, m_pc_d);
            check("instr_d", s_instr, m_instr);
        end else begin
            check("instr_d_bubble", s_instr, NOP);
        end
        check("pc_plus4_d", s_pc4, s_pc + 32'd4);
        granted = s_req && imem_gnt;
        @(posedge clk);
        if (resp) begin
            if (!drop && !pc_src_e) q.push_back('{pend_addr, mem_word(pend_addr)});
            pend = 1'b0;
            drop = 1'b0;
        end else if (pend) begin
            if (pc_src_e) drop = 1'b1;
            pend_cnt--;
        end
        if (pc_src_e) begin
            q.delete();
            m_valid = 1'b0;
            m_instr = NOP;
            m_pc    = pc_target_e;
        end else begin
            if (!stall_d) begin
                if (q.size() > 0) begin
                    e       = q.pop_front();
                    m_valid = 1'b1;
                    m_pc_d  = e.pc;
                    m_instr = e.instr;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end
            if (granted) begin
                pend      = 1'b1;
                pend_addr = m_pc;
                pend_cnt  = lat - 1;
                m_pc      = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        force_rvalid = 1'b0;
        imem_rvalid  = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must take reset values immediately.
    task automatic do_reset();
        rst         = 1'b1;
        stall_d     = 1'b0;
        pc_src_e    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check1("rst_imem_req", imem_req, 1'b0);
        check1("rst_valid_d", valid_d, 1'b0);
        check("rst_instr_d", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_pc_plus4_d", pc_plus4_d, 32'h4);
        pend    = 1'b0;
        drop    = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_instr = NOP;
        m_pc_d  = 32'h0;
        m_pc    = RPC;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_req(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_req && n < 20);
        check1({name, "_seen"}, s_req, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!s_valid && n < 20) begin
            tick();
            n++;
        end
        check1({name, "_seen"}, s_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        int          grants;
        int          n;
        logic [31:0] seen[$];

        tbl[0] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h4};
        tbl[6] = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h8};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h8};

        rst          = 1'b0;
        stall_d      = 1'b0;
        pc_src_e     = 1'b0;
        pc_target_e  = 32'h0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        pend         = 1'b0;
        drop         = 1'b0;
        pend_addr    = 32'h0;
        pend_cnt     = 0;
        lat          = 1;
        gnt_en       = 1'b1;
        force_rvalid = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming from reset with a 1-cycle memory.
        for (int i = 0; i < 8; i++) begin
            stall_d = tbl[i].stall;
            tick();
            check1($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
            if (tbl[i].req) check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            check1($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
            check($sformatf("tbl%0d_pc_d", i), s_pc, tbl[i].pc);
        end

        // Decode stall for 5 cycles: buffer fills to its depth, then order is preserved.
        do_reset();
        tick();
        tick();
        stall_d = 1'b1;
        grants  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_req && imem_gnt) grants++;
        end
        check("stall_grants", 32'(grants), 32'(DEPTH));
        check1("stall_req_blocked", s_req, 1'b0);
        stall_d = 1'b0;
        tick();
        seen.delete();
        for (int i = 0; i < 8 && seen.size() < 2; i++) begin
            tick();
            if (s_valid) seen.push_back(s_pc);
        end
        check("stall_release_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("stall_release_first", seen[0], 32'h4);
            check("stall_release_second", seen[1], 32'h8);
        end

        // Redirect while waiting; the late reply is dropped.
        lat = 3;
        run_until_req("pre_redirect");
        pc_src_e    = 1'b1;
        pc_target_e = 32'h100;
        tick();
        pc_src_e = 1'b0;
        run_until_req("post_redirect");
        check("redirect_addr", s_addr, 32'h100);
        lat = 1;
        wait_valid("redirect_valid");
        check("redirect_pc_d", s_pc, 32'h100);

        // Redirect with stall and a full buffer.
        stall_d = 1'b1;
        n = 0;
        while (!(!pend && q.size() == DEPTH) && n < 20) begin
            tick();
            n++;
        end
        tick();
        check1("full_blocks_req", s_req, 1'b0);
        pc_src_e    = 1'b1;
        pc_target_e = 32'h200;
        tick();
        pc_src_e = 1'b0;
        tick();
        check1("flush_valid_d", s_valid, 1'b0);
        check1("flush_req", s_req, 1'b1);
        check("flush_addr", s_addr, 32'h200);
        stall_d = 1'b0;

        // PC wrap at the top of the address space.
        pc_src_e    = 1'b1;
        pc_target_e = 32'hFFFF_FFFC;
        tick();
        pc_src_e = 1'b0;
        run_until_req("wrap_req");
        check("wrap_addr", s_addr, 32'hFFFF_FFFC);
        run_until_req("wrap_next_req");
        check("wrap_next_addr", s_addr, 32'h0);
        wait_valid("wrap_valid");
        check("wrap_pc_d", s_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4_d", s_pc4, 32'h0);

        // Reset in the middle of an outstanding request, then a stale reply.
        lat = 3;
        run_until_req("pre_reset");
        do_reset();
        force_rvalid = 1'b1;
        gnt_en       = 1'b0;
        tick();
        gnt_en = 1'b1;
        lat    = 1;
        tick();
        check1("stale_rvalid_valid_d", s_valid, 1'b0);
        check1("post_reset_req", s_req, 1'b1);
        check("post_reset_addr", s_addr, RPC);
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction driven on instr_d during bubbles.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; equals the PC.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  fetched instruction.
- stall_d  in  1  decode register hold.
- pc_src_e  in  1  taken branch/jump redirect from execute.
- pc_target_e  in  32  redirect target.
- instr_d  out  32  decode-stage instruction.
- pc_d  out  32  decode-stage PC.
- pc_plus4_d  out  32  pc_d + 4.
- valid_d  out  1  decode-stage content is a real instruction.

Function
REQ-004 The fetch FSM SHALL have states IDLE, WAIT and DROP, and SHALL allow at most one outstanding request.
REQ-005 In IDLE, the FSM SHALL assert imem_req whenever (buffer occupancy) < DEPTH and pc_src_e = 0.
REQ-006 On imem_req & imem_gnt, the FSM SHALL go IDLE->WAIT and the PC SHALL advance by 4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0).
REQ-007 In WAIT, imem_rvalid SHALL push {PC of request, imem_rdata} into the fetch buffer and return to IDLE; a new request SHALL NOT be issued in the same cycle.
REQ-008 pc_src_e = 1 SHALL load PC <= pc_target_e, empty the buffer, and clear valid_d at the next edge.
- If pc_src_e = 1 in WAIT without imem_rvalid, the FSM SHALL go to DROP.
- If pc_src_e = 1 in WAIT with imem_rvalid, the data SHALL be discarded and the FSM SHALL go to IDLE.
REQ-009 In DROP, the next imem_rvalid SHALL be discarded and the FSM SHALL go to IDLE; no request SHALL be issued in DROP.
REQ-010 When stall_d = 0 and pc_src_e = 0, the decode register SHALL load the buffer head (valid_d = 1) and pop it; if the buffer is empty it SHALL load a bubble (valid_d = 0, instr_d = NOP_INSTR).
REQ-011 A response arriving while the buffer is empty and stall_d = 0 SHALL bypass into the decode register in the same edge (fetch-to-decode latency of 1 cycle after rvalid).
REQ-012 When stall_d = 1 and pc_src_e = 0, the decode register SHALL hold and the buffer SHALL keep filling up to DEPTH.
REQ-013 pc_src_e SHALL take priority over stall_d and over every buffer push or pop.
REQ-014 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-015 A full buffer SHALL block imem_req; the buffer SHALL never overflow or underflow.
REQ-016 pc_plus4_d SHALL equal pc_d + 4 (mod 2^32) at all times.

Reset
REQ-017 On rst = 1, asynchronously and regardless of state:
- PC SHALL be RESET_PC.
- The FSM SHALL be IDLE and the buffer empty.
- valid_d SHALL be 0, instr_d NOP_INSTR, pc_d 0 and pc_plus4_d 4.
- imem_req SHALL be 0 while rst = 1.
REQ-018 A response belonging to a request accepted before a mid-operation reset SHALL be ignored (the FSM is IDLE and does not sample rvalid).

Configuration
REQ-019 With IF_SKID_BUF_EN defined, the fetch buffer SHALL have DEPTH = 2, giving back-to-back fetch while decode stalls for one cycle.
REQ-020 Without IF_SKID_BUF_EN, DEPTH SHALL be 1 and all other behaviour SHALL be unchanged.

Structure
REQ-021 A shared package SHALL hold the RESET_PC default, the NOP_INSTR encoding, the FSM state enumeration and the fetch-buffer entry type {pc[31:0], instr[31:0]}.
REQ-022 The fetch buffer SHALL be a sub-module fetch_fifo (parameterised by DEPTH, with push/pop/full/empty).

Verification
REQ-023 A bench SHALL cover at least the following directed scenarios:
- Reset release, 1-cycle memory, stall_d = 0 -> imem_addr 0, 4, 8…; valid_d rises with pc_d = 0 and then increments by 4 every 2 cycles.
- stall_d high 5 cycles with IF_SKID_BUF_EN -> exactly 2 requests are issued, then imem_req stays 0; on release the instructions at PCs 4 and 8 appear in order, with none lost or duplicated.
- pc_src_e = 1 with pc_target_e = 32'h100 while in WAIT, rvalid 2 cycles later -> the late data is dropped; the next imem_addr is 32'h100 and the next valid pc_d is 32'h100.
- pc_src_e and stall_d both high with a full buffer -> the buffer is emptied, valid_d = 0 and PC = target.
- PC = 32'hFFFF_FFFC fetched -> the next imem_addr is 0 and pc_plus4_d = 0.
- rst asserted mid-WAIT, then rvalid pulses -> no buffer push; outputs are at reset values; the first fetch after release is RESET_PC.
